// File: rtl/facing_tracker.sv
// facing_tracker: per-fighter facing from X positions, with deadband, settle filter and turn lock
module facing_tracker #(
  parameter int COORD_W       = 7,
  parameter int DEADBAND      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [COORD_W-1:0] p1_x,
  input  logic [COORD_W-1:0] p2_x,
  input  logic               p1_lock,
  input  logic               p2_lock,
  output logic               p1_facing_right,
  output logic               p2_facing_right,
  output logic               p1_turn,
  output logic               p2_turn,
  output logic               in_deadband
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic signed [COORD_W:0] DB = (COORD_W+1)'(DEADBAND);
  localparam logic [CW-1:0] SC = CW'(SETTLE_CYCLES);
  typedef enum logic {STABLE, PENDING} state_t;
  state_t state_q [2];
  state_t state_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0] facing_q, facing_d, turn_q, turn_d, want, lock;
  logic db_q, db_d, p1_ahead, p2_ahead, in_db;
  logic signed [COORD_W:0] dx;
  assign dx = $signed({1'b0, p1_x}) - $signed({1'b0, p2_x});
  assign p1_ahead = dx > DB;
  assign p2_ahead = dx < -DB;
  assign in_db = !p1_ahead && !p2_ahead;
  // inside the deadband each fighter wants what it already has
  assign want[0] = p2_ahead ? 1'b1 : p1_ahead ? 1'b0 : facing_q[0];
  assign want[1] = p2_ahead ? 1'b0 : p1_ahead ? 1'b1 : facing_q[1];
  assign lock = {p2_lock, p1_lock};
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      facing_d[i] = facing_q[i];
      turn_d[i]   = 1'b0;
      if (en) begin
        if (want[i] == facing_q[i]) begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end else if (state_q[i] == STABLE) begin
          state_d[i] = PENDING;
          cnt_d[i]   = CW'(1);
        end else if (cnt_q[i] != SC) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (!lock[i]) begin
          facing_d[i] = ~facing_q[i];
          turn_d[i]   = 1'b1;
          state_d[i]  = STABLE;
          cnt_d[i]    = '0;
        end
      end
    end
    db_d = en ? in_db : db_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      facing_q <= 2'b01;
      turn_q   <= 2'b00;
      db_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      facing_q <= facing_d;
      turn_q   <= turn_d;
      db_q     <= db_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
  assign p1_facing_right = facing_q[0];
  assign p2_facing_right = facing_q[1];
  assign p1_turn         = turn_q[0];
  assign p2_turn         = turn_q[1];
  assign in_deadband     = db_q;
endmodule

// File: tb/tb_facing_tracker.sv
// tb_facing_tracker: directed vectors, expected outputs queued and checked by a monitor
module tb_facing_tracker;
  logic clk = 1'b0, rst_n, en, p1_lock, p2_lock;
  logic [6:0] p1_x, p2_x;
  logic p1_facing_right, p2_facing_right, p1_turn, p2_turn, in_deadband;
  logic [4:0] exp_q [$];
  int vectors = 0, miscompares = 0;
  facing_tracker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .p1_x(p1_x), .p2_x(p2_x),
    .p1_lock(p1_lock), .p2_lock(p2_lock),
    .p1_facing_right(p1_facing_right), .p2_facing_right(p2_facing_right),
    .p1_turn(p1_turn), .p2_turn(p2_turn), .in_deadband(in_deadband)
  );
  always #5 clk = ~clk;
  // expected word is {p1_facing_right, p2_facing_right, p1_turn, p2_turn, in_deadband}
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [4:0] e, got;
      e = exp_q.pop_front();
      got = {p1_facing_right, p2_facing_right, p1_turn, p2_turn, in_deadband};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vec %0d: f1 f2 t1 t2 db got %b want %b", vectors, got, e);
      end
    end
  end
  task automatic cyc(input logic r, input logic e, input int a, input int b,
                     input logic l1, input logic l2, input logic [4:0] x);
    rst_n = r; en = e; p1_x = 7'(a); p2_x = 7'(b); p1_lock = l1; p2_lock = l2;
    @(posedge clk);
    exp_q.push_back(x);
    @(negedge clk);
  endtask
  task automatic hold(input int n, input logic r, input logic e, input int a, input int b,
                      input logic l1, input logic l2, input logic [4:0] x);
    for (int k = 0; k < n; k++) cyc(r, e, a, b, l1, l2, x);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    hold(2, 0, 1, 10, 50, 0, 0, 5'b10000);
    hold(3, 1, 1, 10, 50, 0, 0, 5'b10000);
    // cross: both turn on the 5th enabled edge, pulse one cycle
    hold(4, 1, 1, 60, 50, 0, 0, 5'b10000);
    cyc(1, 1, 60, 50, 0, 0, 5'b01110);
    hold(2, 1, 1, 60, 50, 0, 0, 5'b01000);
    // jitter: request withdrawn by a deadband sample, then full settle again
    hold(3, 1, 1, 40, 50, 0, 0, 5'b01000);
    cyc(1, 1, 50, 50, 0, 0, 5'b01001);
    hold(4, 1, 1, 40, 50, 0, 0, 5'b01000);
    cyc(1, 1, 40, 50, 0, 0, 5'b10110);
    cyc(1, 1, 40, 50, 0, 0, 5'b10000);
    // deadband, including the |dx| == DEADBAND edge
    hold(20, 1, 1, 51, 50, 0, 0, 5'b10001);
    hold(6, 1, 1, 52, 50, 0, 0, 5'b10001);
    // p1 locked: only p2 turns, p1 turns when lock drops
    hold(4, 1, 1, 60, 50, 1, 0, 5'b10000);
    cyc(1, 1, 60, 50, 1, 0, 5'b11010);
    hold(5, 1, 1, 60, 50, 1, 0, 5'b11000);
    cyc(1, 1, 60, 50, 0, 0, 5'b01100);
    cyc(1, 1, 60, 50, 0, 0, 5'b01000);
    // |dx| == DEADBAND+1 requests a turn
    hold(4, 1, 1, 47, 50, 0, 0, 5'b01000);
    cyc(1, 1, 47, 50, 0, 0, 5'b10110);
    cyc(1, 1, 47, 50, 0, 0, 5'b10000);
    // extremes with p2 locked; en=0 holds the saturated request
    hold(4, 1, 1, 127, 0, 0, 1, 5'b10000);
    cyc(1, 1, 127, 0, 0, 1, 5'b00100);
    hold(2, 1, 1, 127, 0, 0, 1, 5'b00000);
    hold(3, 1, 0, 127, 0, 0, 0, 5'b00000);
    cyc(1, 1, 127, 0, 0, 0, 5'b01010);
    cyc(1, 1, 127, 0, 0, 0, 5'b01000);
    // in_deadband holds while en=0
    cyc(1, 1, 30, 30, 0, 0, 5'b01001);
    hold(2, 1, 0, 0, 127, 0, 0, 5'b01001);
    // reverse extremes, settle paused by en=0
    hold(2, 1, 1, 0, 127, 0, 0, 5'b01000);
    hold(3, 1, 0, 0, 127, 0, 0, 5'b01000);
    hold(2, 1, 1, 0, 127, 0, 0, 5'b01000);
    cyc(1, 1, 0, 127, 0, 0, 5'b10110);
    cyc(1, 1, 0, 127, 0, 0, 5'b10000);
    // reset mid-pending discards progress, even with en=0
    hold(3, 1, 1, 127, 0, 0, 0, 5'b10000);
    cyc(0, 0, 127, 0, 0, 0, 5'b10000);
    hold(4, 1, 1, 127, 0, 0, 0, 5'b10000);
    cyc(1, 1, 127, 0, 0, 0, 5'b01110);
    cyc(1, 1, 127, 0, 0, 0, 5'b01000);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
